multi_cycle_ctrl: RTL
=====================

Name: multi_cycle_ctrl

Overview:
- Main control FSM of the multicycle MIPS CPU; the producing end of the 3-bit ALUOp bus consumed by the ALU-control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath enables and muxes from the 6-bit opcode held in IR.

Parameters:
HALT_ON_ILLEGAL, 1, 1: an undecoded opcode enters sticky HALT; 0: it is treated as NOP and returns to IF.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26]; stable from the cycle after IF
mem_ready  input  1  memory handshake; used only with MEM_WAIT_EN
PCWrite / PCWriteCond  output  1  unconditional PC write / branch-qualified PC write
BranchNe  output  1  0: branch taken on zero; 1: taken on nonzero
IorD  output  1  memory address select, 0=PC, 1=ALUOut
MemRead / MemWrite / IRWrite  output  1  memory and IR strobes
MemtoReg / RegDst / RegWrite  output  1  writeback controls; RegDst 1=rd, 0=rt
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=ext imm, 11=ext imm<<2
ExtOp  output  1  1=sign-extend imm, 0=zero-extend
ALUOp  output  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt, 110 xor
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state, for debug

Behaviour:
- Moore FSM: outputs depend only on state and the latched opcode. Any output not listed for a state is 0.
- Async reset forces INIT (0), in which all outputs are 0 and state=0. The first rising edge after rst deasserts moves INIT -> IF.
- Reset asserted in any state aborts the instruction immediately. No strobe may remain asserted after rst rises.
- Opcode is latched into an internal register on leaving ID. EXEC_I, WB_I and BRANCH use the latched copy.
- IF (1): MemRead, IRWrite, PCWrite, ALUSrcB=01, ALUOp=000. Next state is ID.
- ID (2): ALUSrcB=11, ExtOp=1, ALUOp=000 (branch target goes to ALUOut). Next state by opcode:
  - 100011/101011 -> MADDR
  - 000000 -> EXR
  - 000100/000101 -> BR
  - 000010 -> JMP
  - 001000/001100/001101/001010/001110 -> EXI
  - anything else -> HALT (or IF when HALT_ON_ILLEGAL=0)
- MADDR (3): ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=000. Next state: lw -> MRD, sw -> MWR.
- MRD (4): MemRead, IorD=1. Next state is WBM.
- WBM (5): RegWrite, MemtoReg=1, RegDst=0. Next state is IF.
- MWR (6): MemWrite, IorD=1. Next state is IF.
- EXR (7): ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next state is WBR.
- WBR (8): RegWrite, RegDst=1. Next state is IF.
- BR (9): ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond, PCSource=01, BranchNe=1 for opcode 000101. Next state is IF.
- JMP (10): PCWrite, PCSource=10. Next state is IF.
- EXI (11): ALUSrcA=1, ALUSrcB=10. Next state is WBI. Per opcode:
  - addi: ALUOp 000, ExtOp=1
  - andi: ALUOp 011, ExtOp=0
  - ori: ALUOp 100, ExtOp=0
  - slti: ALUOp 101, ExtOp=1
  - xori: ALUOp 110, ExtOp=0
- WBI (12): RegWrite, RegDst=0, MemtoReg=0. Next state is IF.
- HALT (13): all outputs 0. Exited only by rst.
- Unused encodings 14-15 go to INIT on the next edge.
- Latency in cycles, IF to back-in-IF: lw 5, sw 4, R-type 4, I-type 4, beq/bne 3, j 3.

Optional Feature:
MULTI_CYCLE_CTRL_MEM_WAIT_EN
- Defined:
  - IF, MRD and MWR hold while mem_ready=0.
  - MemRead/MemWrite/IorD stay asserted for the whole hold.
  - In IF, PCWrite and IRWrite assert only in the cycle where mem_ready=1.
  - The state advances on the edge where mem_ready=1.
- Undefined: mem_ready is ignored and every state lasts exactly one cycle.

Test Plan:
- rst pulse mid-MRD of lw (opcode 100011) -> state=0 and all outputs 0 asynchronously; IF is reached one cycle after release.
- lw: opcode 100011 -> state sequence 1,2,3,4,5,1; WBM shows RegWrite=1, MemtoReg=1, RegDst=0.
- andi: opcode 001100 -> EXI outputs ALUOp=011, ExtOp=0, ALUSrcB=10. Repeat for xori: ALUOp=110.
- bne: opcode 000101 -> BR outputs PCWriteCond=1, BranchNe=1, ALUOp=001, PCSource=01; IF follows in 3 cycles total.
- Illegal opcode 111111 -> HALT (13) held for 20 cycles with all outputs 0. With HALT_ON_ILLEGAL=0 it returns to IF after ID.
- With MEM_WAIT_EN, mem_ready low for 3 cycles in IF -> state held at 1 with MemRead=1 and PCWrite=0 for 3 cycles; PCWrite=IRWrite=1 in the ready cycle.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: main control FSM of the multicycle MIPS CPU (IF/ID/EX/MEM/WB sequencing).
// Define MULTI_CYCLE_CTRL_MEM_WAIT_EN to stall IF, MRD and MWR on mem_ready.
module multi_cycle_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_INIT, S_IF, S_ID, S_MADDR, S_MRD, S_WBM, S_MWR, S_EXR,
        S_WBR, S_BR, S_JMP, S_EXI, S_WBI, S_HALT
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                           OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
                           OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_XORI = 6'b001110,
                           OP_LW = 6'b100011, OP_SW = 6'b101011;

    state_t cur, nxt;
    logic [5:0] op_q;
    logic ready;

`ifdef MULTI_CYCLE_CTRL_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur  <= S_INIT;
            op_q <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_ID) op_q <= opcode;
        end
    end

    assign state = cur;

    always_comb begin
        nxt = cur;
        PCWrite = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe = 1'b0;
        IorD = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        IRWrite = 1'b0;
        MemtoReg = 1'b0;
        RegDst = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b00;
        ExtOp = 1'b0;
        ALUOp = 3'b000;
        PCSource = 2'b00;
        case (cur)
            S_INIT: nxt = S_IF;
            S_IF: begin
                MemRead = 1'b1;
                IRWrite = ready;
                PCWrite = ready;
                ALUSrcB = 2'b01;
                nxt = ready ? S_ID : S_IF;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                ExtOp = 1'b1;
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MADDR;
                    OP_R: nxt = S_EXR;
                    OP_BEQ, OP_BNE: nxt = S_BR;
                    OP_J: nxt = S_JMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI: nxt = S_EXI;
                    default: nxt = HALT_ON_ILLEGAL ? S_HALT : S_IF;
                endcase
            end
            S_MADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp = 1'b1;
                nxt = (op_q == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD = 1'b1;
                nxt = ready ? S_WBM : S_MRD;
            end
            S_WBM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                nxt = S_IF;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                IorD = 1'b1;
                nxt = ready ? S_IF : S_MWR;
            end
            S_EXR: begin
                ALUSrcA = 1'b1;
                ALUOp = 3'b010;
                nxt = S_WBR;
            end
            S_WBR: begin
                RegWrite = 1'b1;
                RegDst = 1'b1;
                nxt = S_IF;
            end
            S_BR: begin
                ALUSrcA = 1'b1;
                ALUOp = 3'b001;
                PCWriteCond = 1'b1;
                PCSource = 2'b01;
                BranchNe = (op_q == OP_BNE);
                nxt = S_IF;
            end
            S_JMP: begin
                PCWrite = 1'b1;
                PCSource = 2'b10;
                nxt = S_IF;
            end
            S_EXI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp = (op_q == OP_ADDI) || (op_q == OP_SLTI);
                ALUOp = (op_q == OP_ANDI) ? 3'b011 :
                        (op_q == OP_ORI)  ? 3'b100 :
                        (op_q == OP_SLTI) ? 3'b101 :
                        (op_q == OP_XORI) ? 3'b110 : 3'b000;
                nxt = S_WBI;
            end
            S_WBI: begin
                RegWrite = 1'b1;
                nxt = S_IF;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_INIT;
        endcase
    end
endmodule
